// File: rtl/sm_sdram_memtest_if.sv
// User-port bus between the SDRAM memory-test sequencer and the SDRAM controller.
// The sequencer takes the master modport and the controller takes the slave modport.
interface sm_sdram_memtest_if #(
   parameter int AW = 6,
   parameter int DW = 32
);
   logic          cs;
   logic          we;
   logic [AW-1:0] a;
   logic [DW-1:0] wd;
   logic          ready;
   logic [DW-1:0] rd;

   modport master (output cs, we, a, wd, input ready, rd);
   modport slave  (input cs, we, a, wd, output ready, rd);
endinterface

// File: rtl/sm_sdram_memtest.sv
// SDRAM self-test sequencer: writes a pattern over 0..DEPTH-1, reads it back, and counts mismatches.
// Define SM_MEMTEST_INVPASS_EN to add a second write/read pass that uses the inverted pattern.
module sm_sdram_memtest #(
   parameter int          AW    = 6,
   parameter int          DW    = 32,
   parameter int          DEPTH = 64,
   parameter logic [31:0] SEED  = 32'h87654321
) (
   input  logic                clkIn,
   input  logic                rst_n,
   sm_sdram_memtest_if.master  mem,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [3:0]          sel,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [15:0]         err_cnt,
   output logic [AW-1:0]       first_err_addr,
   output logic [3:0]          disp
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic            cs_q, cs_d, we_q, we_d;
   logic [AW-1:0]   a_q, a_d;
   logic [DW-1:0]   wd_q, wd_d;
   logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [15:0]     err_cnt_q, err_cnt_d;
   logic [AW-1:0]   first_err_q, first_err_d;
   logic [DW-1:0]   last_rd_q, last_rd_d;
   logic [1:0]      mode_q, mode_d;
   logic            wt_q, wt_d;
   logic            inv_q, inv_d;
   logic [3:0]      disp_q, disp_d;
   logic            last_idx;
   logic [15:0]     lr16;

   function automatic logic [DW-1:0] pat_word(input logic [1:0] m, input logic [AW-1:0] idx,
                                              input logic inv);
      logic [DW-1:0] p;
      case (m)
         2'd0:    p = DW'(idx);
         2'd1:    p = {{(DW-1){1'b0}}, 1'b1} << (32'(idx) % DW);
         2'd2:    p = DW'(SEED) ^ DW'(idx);
         default: p = idx[0] ? {(DW/2){2'b01}} : {(DW/2){2'b10}};
      endcase
      return inv ? ~p : p;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   assign mem.cs         = cs_q;
   assign mem.we         = we_q;
   assign mem.a          = a_q;
   assign mem.wd         = wd_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_cnt        = err_cnt_q;
   assign first_err_addr = first_err_q;
   assign disp           = disp_q;

   assign last_idx = (a_q == AW'(DEPTH - 1));

   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cs_q        <= 1'b0;
         we_q        <= 1'b0;
         a_q         <= '0;
         wd_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         last_rd_q   <= '0;
         mode_q      <= '0;
         wt_q        <= 1'b0;
         inv_q       <= 1'b0;
         disp_q      <= '0;
      end else begin
         state_q     <= state_d;
         cs_q        <= cs_d;
         we_q        <= we_d;
         a_q         <= a_d;
         wd_q        <= wd_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         last_rd_q   <= last_rd_d;
         mode_q      <= mode_d;
         wt_q        <= wt_d;
         inv_q       <= inv_d;
         disp_q      <= disp_d;
      end
   end

   // wt_q marks the second and later wait cycles; the controller's ready can still be
   // high from the acceptance cycle during the first one.
   always_comb begin
      state_d     = state_q;
      cs_d        = cs_q;
      we_d        = we_q;
      a_d         = a_q;
      wd_d        = wd_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      last_rd_d   = last_rd_q;
      mode_d      = mode_q;
      wt_d        = wt_q;
      inv_d       = inv_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               pass_d = (err_cnt_q == 16'd0);
            end
            if (start) begin
               mode_d      = mode;
               inv_d       = 1'b0;
               err_cnt_d   = '0;
               first_err_d = '0;
               pass_d      = 1'b0;
               done_d      = 1'b0;
               busy_d      = 1'b1;
               cs_d        = 1'b1;
               we_d        = 1'b1;
               a_d         = '0;
               wd_d        = pat_word(mode, '0, 1'b0);
               state_d     = S_WR_REQ;
            end
         end
         S_WR_REQ: begin
            if (mem.ready) begin
               cs_d    = 1'b0;
               wt_d    = 1'b0;
               state_d = S_WR_WAIT;
            end
         end
         S_WR_WAIT: begin
            wt_d = 1'b1;
            if (wt_q && mem.ready) begin
               cs_d = 1'b1;
               if (last_idx) begin
                  a_d     = '0;
                  we_d    = 1'b0;
                  state_d = S_RD_REQ;
               end else begin
                  a_d     = a_q + 1'b1;
                  we_d    = 1'b1;
                  wd_d    = pat_word(mode_q, a_q + 1'b1, inv_q);
                  state_d = S_WR_REQ;
               end
            end
         end
         S_RD_REQ: begin
            if (mem.ready) begin
               cs_d    = 1'b0;
               wt_d    = 1'b0;
               state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            wt_d = 1'b1;
            if (wt_q && mem.ready) begin
               last_rd_d = mem.rd;
               if (mem.rd != pat_word(mode_q, a_q, inv_q)) begin
                  if (err_cnt_q == 16'd0) first_err_d = a_q;
                  err_cnt_d = sat_inc(err_cnt_q);
               end
               if (!last_idx) begin
                  a_d     = a_q + 1'b1;
                  cs_d    = 1'b1;
                  we_d    = 1'b0;
                  state_d = S_RD_REQ;
               end else begin
`ifdef SM_MEMTEST_INVPASS_EN
                  if (!inv_q) begin
                     inv_d   = 1'b1;
                     a_d     = '0;
                     cs_d    = 1'b1;
                     we_d    = 1'b1;
                     wd_d    = pat_word(mode_q, '0, 1'b1);
                     state_d = S_WR_REQ;
                  end else begin
                     state_d = S_DONE;
                  end
`else
                  state_d = S_DONE;
`endif
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bits of last_rd above DW-1 read as zero on the display.
   always_comb begin
      lr16 = 16'(last_rd_q);
      case (sel)
         4'b1110: disp_d = lr16[7:4];
         4'b1101: disp_d = lr16[11:8];
         4'b1011: disp_d = lr16[15:12];
         4'b0111: disp_d = {pass_q, done_q, busy_q, err_cnt_q != 16'd0};
         default: disp_d = lr16[3:0];
      endcase
   end

endmodule
